// File: rtl/rca_pkg.sv
// +----------------------------------------------------------------------+
// | rca_pkg : shared types and sizing helpers for the sliced RCA sequencer |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int nslice_of(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice datapath still needs a 1-bit index.
    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rca_behavioural.sv
// +----------------------------------------------------------------------+
// | rca_behavioural : SLICE_W-bit ripple-carry adder slice                 |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module rca_behavioural
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | rca_seq_ctrl : WIDTH-bit add/sub, one SLICE-bit RCA time-shared LSB-first |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = nslice_of(WIDTH, SLICE);
    localparam int IDX_W  = idx_width(NSLICE);
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;

    assign slice_a = a_q[idx_q*SLICE +: SLICE];
    assign slice_b = b_q[idx_q*SLICE +: SLICE];

    rca_behavioural u_slice_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*SLICE +: SLICE] <= slice_s;
                    carry_q                     <= slice_cout;
                    // Index parks on the last slice instead of wrapping.
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        ovf_q       <= (a_q[MSB] == b_q[MSB]) && (slice_s[SLICE-1] != a_q[MSB]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_rca_seq_ctrl : directed scoreboard bench for rca_seq_ctrl           |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rca_seq_ctrl;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference built from integer arithmetic, independent of slicing.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic cv, input logic sv);
        exp_t        m;
        int          sa;
        int          sbv;
        int          r;
        logic [16:0] u;
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        if (sv) begin
            r      = sa - sbv;
            m.sum  = av - bv;
            m.cout = (av >= bv);
        end else begin
            r      = sa + sbv + int'(cv);
            u      = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
            m.sum  = u[15:0];
            m.cout = u[16];
        end
        m.ovf = (r > 32767) || (r < -32768);
        return m;
    endfunction

    task automatic issue_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic sv);
        int n;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
        sb_q.push_back(model(av, bv, cv, sv));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_run", {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 32'd4);
    endtask

    task automatic finish_op(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"},  {16'd0, sum}, {16'd0, e.sum});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.cout});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e.ovf});
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_busy_drop"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum",       {16'd0, sum}, 32'd0);
        check("rst_cout",      {31'd0, cout}, 32'd0);
        check("rst_ovf",       {31'd0, ovf}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;

        issue_op(16'h0006, 16'h0004, 1'b0, 1'b0); finish_op("add_basic");
        issue_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op("add_ripple");
        issue_op(16'h000F, 16'h0000, 1'b1, 1'b0); finish_op("add_cin");
        issue_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op("add_ovf");
        issue_op(16'h8000, 16'h0001, 1'b0, 1'b1); finish_op("sub_ovf");
        issue_op(16'h0003, 16'h0005, 1'b1, 1'b1); finish_op("sub_borrow");
        issue_op(16'h0007, 16'h0007, 1'b0, 1'b1); finish_op("sub_equal");

        // Backpressure with a competing in_valid during DONE.
        out_ready = 1'b0;
        issue_op(16'h1000, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'hDEAD;
            b        = 16'hBEEF;
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum",       {16'd0, sum}, {16'd0, sb_q[0].sum});
            check("bp_cout",      {31'd0, cout}, {31'd0, sb_q[0].cout});
            check("bp_ovf",       {31'd0, ovf}, {31'd0, sb_q[0].ovf});
            check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp_release");
        issue_op(16'h0111, 16'h0222, 1'b0, 1'b0); finish_op("bp_next");

        // Asynchronous reset after the second RUN edge.
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sum",       {16'd0, sum}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy",      {31'd0, busy}, 32'd0);
        check("arst_in_ready",  {31'd0, in_ready}, 32'd0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("arst_no_stale", {31'd0, out_valid}, 32'd0);
        issue_op(16'h1234, 16'h1111, 1'b0, 1'b0); finish_op("arst_retry");

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit add or subtract by time-sharing one SLICE-bit ripple-carry adder (rca_behavioural) over WIDTH/SLICE cycles, LSB slice first.
- Carry is registered between slices.
- Operands enter through a valid/ready input handshake; the result leaves through a valid/ready output handshake.
- Sits between the operand-issue logic and the result consumer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, adder slice width; fixed to match rca_behavioural.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, i.e. a + ~b + 1, with cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB slice; for sub, 1 means no borrow.
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high. rst asserted forces the state and all registers to reset values immediately; release is synchronous to clk.
  - Reset values: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, slice index=0, carry register=0.
  - in_ready is forced 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a into a_reg and b_reg = sub ? ~b : b.
  - Set carry = sub ? 1 : cin, idx=0, and go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge adds slice idx: rca a=a_reg[idx*SLICE +: SLICE], b=b_reg[same slice], cin=carry.
  - Write s into sum_reg[same slice]; carry <= rca cout; idx <= idx+1.
  - On the last slice (idx=WIDTH/SLICE-1), also:
    - set cout <= rca cout;
    - set ovf <= (a_reg[MSB] == b_reg[MSB]) && (s[SLICE-1] != a_reg[MSB]);
    - go to DONE.
- DONE:
  - out_valid=1; sum/cout/ovf are held stable.
  - On an edge with out_ready=1, go to IDLE with out_valid=0.
  - sum/cout/ovf keep their last values until the next operation overwrites them slice by slice.
  - in_ready=0. There is no same-cycle re-accept, so back-to-back operations cost one IDLE cycle.
- Latency: out_valid rises NSLICE=WIDTH/SLICE rising edges after the accepting edge (4 for the defaults). Throughput is one result per NSLICE+2 cycles with out_ready held high.
- The sum output is driven from sum_reg and may show partial values during RUN. Consumers must qualify it with out_valid.
- idx width is clog2(NSLICE), minimum 1. idx never wraps within an operation; it is cleared on accept.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no out_valid is produced, and the block returns to IDLE.
- busy = (state != IDLE).

Decomposition:
- Shared package rca_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - SLICE_W=4;
  - the function for NSLICE/idx width.
- One sub-module: rca_behavioural (ports a, b, cin, s, cout), instantiated once as the shared slice adder.
- All sequencing stays in rca_seq_ctrl.

Test Plan:
- Basic add: a=0x0006, b=0x0004, cin=0, sub=0, out_ready=1 → sum=0x000A, cout=0, ovf=0; out_valid exactly 4 edges after accept, high for 1 cycle.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x000F, b=0x0000, cin=1 → sum=0x0010, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Then sub with a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Subtract with borrow: sub=1, a=0x0003, b=0x0005, cin=1 (must be ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0007 → sum=0x0000, cout=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid → sum/cout/ovf/out_valid stay stable, in_ready=0, and a concurrent in_valid is not captured. Raise out_ready → out_valid=0 and in_ready=1 on the next cycle; the next operation 0x0111+0x0222 gives 0x0333.
- Reset mid-operation: assert rst asynchronously after the 2nd RUN edge of 0x1234+0x1111 → immediately sum=0, out_valid=0, busy=0. After release, in_ready=1; 0x1234+0x1111 then gives 0x2345, cout=0, with no stale result emitted.
